fill_evict_ctrl: RTL and testbench

//  Sequencer for the 4-way L1 downstream of tag compare. Per lookup result it:
//  - on a hit, updates PLRU and dirty state;
//  - on a miss, writes back the dirty victim, fetches the fill line, then writes tag/val/mod/lru.
//  It is the writer of the tag/state arrays that the compare stage reads.

---
 rtl/fill_evict_ctrl_pkg.sv | 26 ++
 rtl/fill_evict_ctrl_plru_update.sv | 35 +++
 rtl/fill_evict_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fill_evict_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fill_evict_ctrl_pkg.sv
// Shared definitions for the L1 fill/evict sequencer:
// FSM encoding, PLRU bit positions and default geometry.
package fill_evict_ctrl_pkg;

    localparam int TAG_W_DEF = 14;
    localparam int IDX_W_DEF = 8;

    // PLRU bit positions inside the 3-bit tree
    localparam int PLRU_ROOT = 2;
    localparam int PLRU_HI   = 1;
    localparam int PLRU_LO   = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WB   = 3'd1,
        S_RD   = 3'd2,
        S_RW   = 3'd3,
        S_UPD  = 3'd4
    } fe_state_t;

    // Keep only the lowest set bit of a way vector
    function automatic logic [3:0] lowest_way(input logic [3:0] way);
        return way & (~way + 4'd1);
    endfunction

endpackage

// File: rtl/fill_evict_ctrl_plru_update.sv
// Tree-PLRU update for a 4-way set: points the tree away
// from the accessed way and keeps the untouched leaf bit.
module plru_update
    import fill_evict_ctrl_pkg::*;
(
    input  logic [2:0] lru_in,
    input  logic [3:0] way,
    output logic [2:0] lru_out
);

    // Lowest set way bit wins if the vector is not one-hot
    always_comb begin
        lru_out = lru_in;
        priority case (1'b1)
            way[0]: begin
                lru_out[PLRU_ROOT] = 1'b0;
                lru_out[PLRU_LO]   = 1'b0;
            end
            way[1]: begin
                lru_out[PLRU_ROOT] = 1'b0;
                lru_out[PLRU_LO]   = 1'b1;
            end
            way[2]: begin
                lru_out[PLRU_ROOT] = 1'b1;
                lru_out[PLRU_HI]   = 1'b0;
            end
            way[3]: begin
                lru_out[PLRU_ROOT] = 1'b1;
                lru_out[PLRU_HI]   = 1'b1;
            end
            default: lru_out = lru_in;
        endcase
    end

endmodule

// File: rtl/fill_evict_ctrl.sv
// L1 fill/evict sequencer: hit state update, victim writeback, line fill.
// Optional counters enabled by defining FILL_EVICT_STATS_EN.
module fill_evict_ctrl
    import fill_evict_ctrl_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_hit,
    input  logic                   req_write,
    input  logic [3:0]             req_way,
    input  logic                   req_victim_dirty,
    input  logic [TAG_W-1:0]       req_tag,
    input  logic [IDX_W-1:0]       req_index,
    input  logic [TAG_W-1:0]       victim_tag,
    input  logic [2:0]             lru_in,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [TAG_W+IDX_W-1:0] wb_addr,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [TAG_W+IDX_W-1:0] rd_addr,
    input  logic                   rd_resp_valid,
    output logic                   arr_wr_en,
    output logic                   arr_tag_wr,
    output logic [3:0]             arr_way,
    output logic [IDX_W-1:0]       arr_index,
    output logic [TAG_W-1:0]       arr_tag,
    output logic                   arr_val,
    output logic                   arr_mod,
    output logic [2:0]             arr_lru,
    output logic                   busy
`ifdef FILL_EVICT_STATS_EN
    ,
    output logic [31:0]            stat_hits,
    output logic [31:0]            stat_misses,
    output logic [31:0]            stat_wbs
`endif
);

    fe_state_t        state;
    fe_state_t        state_nxt;

    logic             cap_hit;
    logic             cap_write;
    logic             cap_dirty;
    logic [3:0]       cap_way;
    logic [TAG_W-1:0] cap_tag;
    logic [IDX_W-1:0] cap_index;
    logic [TAG_W-1:0] cap_vtag;
    logic [2:0]       cap_lru;
    logic [2:0]       lru_new;

    logic             accept;
    logic             wb_hs;
    logic             rd_hs;
    logic             upd;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign wb_valid  = (state == S_WB);
    assign rd_valid  = (state == S_RD);
    assign wb_hs     = wb_valid && wb_ready;
    assign rd_hs     = rd_valid && rd_ready;
    assign upd       = (state == S_UPD);
    assign busy      = (state != S_IDLE);

    // Addresses come from captured fields so they hold while valid
    assign wb_addr   = {cap_vtag, cap_index};
    assign rd_addr   = {cap_tag, cap_index};

    plru_update u_plru (
        .lru_in  (cap_lru),
        .way     (cap_way),
        .lru_out (lru_new)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_hit)
                        state_nxt = S_UPD;
                    else if (req_victim_dirty)
                        state_nxt = S_WB;
                    else
                        state_nxt = S_RD;
                end
            end
            S_WB:    if (wb_hs) state_nxt = S_RD;
            S_RD:    if (rd_hs) state_nxt = S_RW;
            S_RW:    if (rd_resp_valid) state_nxt = S_UPD;
            S_UPD:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the lookup result once; later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_hit   <= 1'b0;
            cap_write <= 1'b0;
            cap_dirty <= 1'b0;
            cap_way   <= '0;
            cap_tag   <= '0;
            cap_index <= '0;
            cap_vtag  <= '0;
            cap_lru   <= '0;
        end else if (accept) begin
            cap_hit   <= req_hit;
            cap_write <= req_write;
            cap_dirty <= req_victim_dirty;
            cap_way   <= lowest_way(req_way);
            cap_tag   <= req_tag;
            cap_index <= req_index;
            cap_vtag  <= victim_tag;
            cap_lru   <= lru_in;
        end
    end

    // Array write fields; state bits only meaningful during the strobe
    always_comb begin
        arr_wr_en  = upd;
        arr_tag_wr = 1'b0;
        arr_val    = 1'b0;
        arr_mod    = 1'b0;
        arr_lru    = '0;
        arr_way    = cap_way;
        arr_index  = cap_index;
        arr_tag    = cap_tag;
        if (upd) begin
            arr_tag_wr = !cap_hit;
            arr_val    = 1'b1;
            arr_lru    = lru_new;
            // On a hit the dirty flag carries the hit way's mod bit
            if (cap_hit)
                arr_mod = cap_dirty | cap_write;
            else
                arr_mod = cap_write;
        end
    end

`ifdef FILL_EVICT_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbs    <= '0;
        end else begin
            if (accept && req_hit && stat_hits != 32'hFFFF_FFFF)
                stat_hits <= stat_hits + 32'd1;
            if (accept && !req_hit && stat_misses != 32'hFFFF_FFFF)
                stat_misses <= stat_misses + 32'd1;
            if (wb_hs && stat_wbs != 32'hFFFF_FFFF)
                stat_wbs <= stat_wbs + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_way_onehot: assert property (
        @(posedge clk) disable iff (reset)
        accept |-> $onehot(req_way)
    );
`endif

endmodule

// File: tb/tb_fill_evict_ctrl.sv
// Directed bench for fill_evict_ctrl: hit, clean/dirty miss,
// ignored responses, async reset mid-fill, optional counters.
module tb_fill_evict_ctrl;

    localparam int TAG_W = 14;
    localparam int IDX_W = 8;
    localparam int AW    = TAG_W + IDX_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_hit;
    logic             req_write;
    logic [3:0]       req_way;
    logic             req_victim_dirty;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] victim_tag;
    logic [2:0]       lru_in;
    logic             wb_valid;
    logic             wb_ready;
    logic [AW-1:0]    wb_addr;
    logic             rd_valid;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr;
    logic             rd_resp_valid;
    logic             arr_wr_en;
    logic             arr_tag_wr;
    logic [3:0]       arr_way;
    logic [IDX_W-1:0] arr_index;
    logic [TAG_W-1:0] arr_tag;
    logic             arr_val;
    logic             arr_mod;
    logic [2:0]       arr_lru;
    logic             busy;
`ifdef FILL_EVICT_STATS_EN
    logic [31:0]      stat_hits;
    logic [31:0]      stat_misses;
    logic [31:0]      stat_wbs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fill_evict_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_hit          (req_hit),
        .req_write        (req_write),
        .req_way          (req_way),
        .req_victim_dirty (req_victim_dirty),
        .req_tag          (req_tag),
        .req_index        (req_index),
        .victim_tag       (victim_tag),
        .lru_in           (lru_in),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_addr          (wb_addr),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_addr          (rd_addr),
        .rd_resp_valid    (rd_resp_valid),
        .arr_wr_en        (arr_wr_en),
        .arr_tag_wr       (arr_tag_wr),
        .arr_way          (arr_way),
        .arr_index        (arr_index),
        .arr_tag          (arr_tag),
        .arr_val          (arr_val),
        .arr_mod          (arr_mod),
        .arr_lru          (arr_lru),
        .busy             (busy)
`ifdef FILL_EVICT_STATS_EN
        ,
        .stat_hits        (stat_hits),
        .stat_misses      (stat_misses),
        .stat_wbs         (stat_wbs)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic hit, input logic wr,
                             input logic [3:0] way, input logic dirty,
                             input logic [13:0] tag, input logic [7:0] idx,
                             input logic [13:0] vtag, input logic [2:0] lru);
        req_valid        = 1'b1;
        req_hit          = hit;
        req_write        = wr;
        req_way          = way;
        req_victim_dirty = dirty;
        req_tag          = tag;
        req_index        = idx;
        victim_tag       = vtag;
        lru_in           = lru;
    endtask

    // Scramble request inputs to show they are not re-sampled
    task automatic drop_req();
        req_valid        = 1'b0;
        req_hit          = ~req_hit;
        req_write        = ~req_write;
        req_way          = 4'b1000;
        req_victim_dirty = ~req_victim_dirty;
        req_tag          = 14'h3FFF;
        req_index        = 8'hFF;
        victim_tag       = 14'h2AAA;
        lru_in           = 3'b111;
    endtask

    task automatic do_hit(input logic [3:0] way);
        drive_req(1'b1, 1'b0, way, 1'b0, 14'h0001, 8'h01, 14'h0, 3'b000);
        step();
        drop_req();
        step();
    endtask

    task automatic do_miss(input logic dirty);
        drive_req(1'b0, 1'b0, 4'b0001, dirty, 14'h0005, 8'h05,
                  14'h0006, 3'b000);
        step();
        drop_req();
        wb_ready = 1'b1;
        rd_ready = 1'b1;
        if (dirty) step();
        step();
        wb_ready = 1'b0;
        rd_ready = 1'b0;
        rd_resp_valid = 1'b1;
        step();
        rd_resp_valid = 1'b0;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        wb_ready      = 1'b0;
        rd_ready      = 1'b0;
        rd_resp_valid = 1'b0;
        drive_req(1'b0, 1'b0, 4'b0001, 1'b0, 14'h0, 8'h0, 14'h0, 3'b000);
        req_valid = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_en", arr_wr_en, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_arr_tag", arr_tag, 0);
        reset = 1'b0;
        step();
        chk("idle_ready", req_ready, 1);

        // Store hit, way2, lru 000 -> 100
        drive_req(1'b1, 1'b1, 4'b0100, 1'b0, 14'h0123, 8'h44,
                  14'h0, 3'b000);
        step();
        drop_req();
        chk("hit_wr_en", arr_wr_en, 1);
        chk("hit_lru", arr_lru, 3'b100);
        chk("hit_mod", arr_mod, 1);
        chk("hit_tag_wr", arr_tag_wr, 0);
        chk("hit_val", arr_val, 1);
        chk("hit_way", arr_way, 4'b0100);
        chk("hit_index", arr_index, 8'h44);
        chk("hit_ready", req_ready, 0);
        step();
        chk("hit_done_wr", arr_wr_en, 0);
        chk("hit_done_busy", busy, 0);

        // Clean miss, way0, lru 101 -> 000
        drive_req(1'b0, 1'b0, 4'b0001, 1'b0, 14'h0ABC, 8'h12,
                  14'h0777, 3'b101);
        step();
        drop_req();
        chk("cm_rd_valid", rd_valid, 1);
        chk("cm_wb_valid", wb_valid, 0);
        chk("cm_rd_addr", rd_addr, 22'h0ABC12);
        rd_ready      = 1'b1;
        rd_resp_valid = 1'b1;
        step();
        rd_ready      = 1'b0;
        rd_resp_valid = 1'b0;
        chk("cm_same_cyc_resp", arr_wr_en, 0);
        chk("cm_rw_busy", busy, 1);
        chk("cm_rw_rd_valid", rd_valid, 0);
        step();
        chk("cm_wait_resp", arr_wr_en, 0);
        rd_resp_valid = 1'b1;
        step();
        rd_resp_valid = 1'b0;
        chk("cm_wr_en", arr_wr_en, 1);
        chk("cm_tag", arr_tag, 14'h0ABC);
        chk("cm_tag_wr", arr_tag_wr, 1);
        chk("cm_val", arr_val, 1);
        chk("cm_mod", arr_mod, 0);
        chk("cm_lru", arr_lru, 3'b000);
        chk("cm_way", arr_way, 4'b0001);
        step();
        chk("cm_done_busy", busy, 0);

        // Dirty store miss, way3, lru 000 -> 110
        drive_req(1'b0, 1'b1, 4'b1000, 1'b1, 14'h0222, 8'h03,
                  14'h1111, 3'b000);
        step();
        drop_req();
        chk("dm_wb_valid", wb_valid, 1);
        chk("dm_wb_addr", wb_addr, 22'h111103);
        chk("dm_no_rd", rd_valid, 0);
        for (int i = 0; i < 5; i++) begin
            rd_resp_valid = (i % 2 == 0);
            step();
            chk("dm_wb_hold", wb_valid, 1);
            chk("dm_wb_addr_hold", wb_addr, 22'h111103);
            chk("dm_hold_no_rd", rd_valid, 0);
        end
        rd_resp_valid = 1'b0;
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("dm_wb_done", wb_valid, 0);
        chk("dm_rd_valid", rd_valid, 1);
        chk("dm_rd_addr", rd_addr, 22'h022203);
        rd_resp_valid = 1'b1;
        step();
        rd_resp_valid = 1'b0;
        chk("dm_rd_resp_ign", rd_valid, 1);
        chk("dm_rd_no_wr", arr_wr_en, 0);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("dm_rw_no_wr", arr_wr_en, 0);
        rd_resp_valid = 1'b1;
        step();
        rd_resp_valid = 1'b0;
        chk("dm_wr_en", arr_wr_en, 1);
        chk("dm_tag", arr_tag, 14'h0222);
        chk("dm_mod", arr_mod, 1);
        chk("dm_lru", arr_lru, 3'b110);
        step();
        chk("dm_done_busy", busy, 0);

        // Async reset while waiting in RW
        drive_req(1'b0, 1'b0, 4'b0010, 1'b0, 14'h0033, 8'h09,
                  14'h0, 3'b000);
        step();
        drop_req();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("rr_in_rw", busy, 1);
        #2;
        reset = 1'b1;
        rd_resp_valid = 1'b1;
        #1;
        chk("rr_busy", busy, 0);
        chk("rr_rd_valid", rd_valid, 0);
        chk("rr_wb_valid", wb_valid, 0);
        chk("rr_wr_en", arr_wr_en, 0);
        step();
        chk("rr_edge_wr_en", arr_wr_en, 0);
        reset = 1'b0;
        rd_resp_valid = 1'b0;
        step();
        chk("rr_post_wr_en", arr_wr_en, 0);
        chk("rr_ready", req_ready, 1);

        // Load hit on a modified way1 after reset: mod kept, lru 001
        drive_req(1'b1, 1'b0, 4'b0010, 1'b1, 14'h0044, 8'h0A,
                  14'h0, 3'b000);
        step();
        drop_req();
        chk("ph_wr_en", arr_wr_en, 1);
        chk("ph_mod", arr_mod, 1);
        chk("ph_lru", arr_lru, 3'b001);
        step();
        chk("ph_idle", busy, 0);

`ifdef FILL_EVICT_STATS_EN
        reset = 1'b1;
        step();
        chk("st_rst_hits", stat_hits, 0);
        reset = 1'b0;
        step();
        do_hit(4'b0001);
        do_miss(1'b1);
        do_hit(4'b0100);
        do_miss(1'b0);
        do_hit(4'b1000);
        chk("st_hits", stat_hits, 3);
        chk("st_misses", stat_misses, 2);
        chk("st_wbs", stat_wbs, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
